// File: rtl/sat_accelerator_top.sv
// sat_accelerator_top
// Brute-force CNF satisfiability engine. One bit per candidate assignment of
// N Boolean variables (2^N bits) is kept. All assignments are evaluated in
// parallel as clauses are streamed in one command per clock.
//
// Commands (stateVal):
//   00 RESET         : clear clause, set cnf to all ones, clear result
//   01 COMPUTE CLAUSE: OR the literal (varPos, negCtrl) into the clause
//   10 COMPUTE CNF   : AND the clause into cnf; the result is |new cnf
//   11 RESET CLAUSE  : clear the clause only
//
// Optional feature macro: SAT_WITNESS_EN
//   When it is defined, the satWitness output reports the lowest satisfying
//   assignment index of the committed formula.
//
// resetN is a synchronous, active-high reset. The name is kept for
// compatibility with existing integrations.
module sat_accelerator_top #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         resetN,
  input  logic [1:0]   stateVal,
  input  logic [4:0]   varPos,
  input  logic         negCtrl,
  output logic         outSATRes
`ifdef SAT_WITNESS_EN
  ,
  output logic [N-1:0] satWitness
`endif
);

  localparam int SIZE = 2 ** N;

  localparam logic [1:0] OP_RESET        = 2'b00;
  localparam logic [1:0] OP_CLAUSE       = 2'b01;
  localparam logic [1:0] OP_CNF          = 2'b10;
  localparam logic [1:0] OP_RESET_CLAUSE = 2'b11;

  localparam logic [4:0] N_VARS = 5'(N);

  // Literal truth table: bit a is the value of variable pos in assignment a,
  // optionally inverted.
  function automatic logic [SIZE-1:0] build_literal(input logic [4:0] pos,
                                                    input logic       neg);
    logic [SIZE-1:0] lit;
    logic [31:0]     a_bits;
    lit = '0;
    for (int a = 0; a < SIZE; a++) begin
      a_bits = 32'(a);
      lit[a] = a_bits[pos] ^ neg;
    end
    return lit;
  endfunction

`ifdef SAT_WITNESS_EN
  // Lowest set index of vec. The result is 0 when no bit is set.
  function automatic logic [N-1:0] lowest_set(input logic [SIZE-1:0] vec);
    logic [N-1:0] idx;
    idx = '0;
    for (int a = SIZE - 1; a >= 0; a--) begin
      if (vec[a]) begin
        idx = N'(a);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction
`endif

  logic [SIZE-1:0] clause_r;
  logic [SIZE-1:0] cnf_r;
  logic            sat_r;
  logic [SIZE-1:0] literal_s;
  logic            in_range_s;
  logic [SIZE-1:0] cnf_next_s;

  // Decode the literal and form the candidate conjunction for a commit.
  always_comb begin
    in_range_s = (varPos < N_VARS);
    if (in_range_s) begin
      literal_s = build_literal(varPos, negCtrl);
    end else begin
      literal_s = '0;
    end
    cnf_next_s = cnf_r & clause_r;
  end

  // Command execution: every opcode completes on the edge it is sampled.
  always_ff @(posedge clk) begin
    if (resetN) begin
      clause_r <= '0;
      cnf_r    <= '1;
      sat_r    <= 1'b0;
    end else begin
      case (stateVal)
        OP_RESET: begin
          clause_r <= '0;
          cnf_r    <= '1;
          sat_r    <= 1'b0;
        end
        OP_CLAUSE: begin
          if (in_range_s) begin
            clause_r <= clause_r | literal_s;
          end else begin
            clause_r <= clause_r;
          end
        end
        OP_CNF: begin
          cnf_r <= cnf_next_s;
          sat_r <= |cnf_next_s;
        end
        OP_RESET_CLAUSE: begin
          clause_r <= '0;
        end
        default: begin
          clause_r <= clause_r;
        end
      endcase
    end
  end

  assign outSATRes = sat_r;

`ifdef SAT_WITNESS_EN
  logic [N-1:0] witness_r;

  // Witness tracks the lowest satisfying assignment on each commit.
  always_ff @(posedge clk) begin
    if (resetN) begin
      witness_r <= '0;
    end else begin
      case (stateVal)
        OP_RESET: witness_r <= '0;
        OP_CNF:   witness_r <= lowest_set(cnf_next_s);
        default:  witness_r <= witness_r;
      endcase
    end
  end

  assign satWitness = witness_r;
`endif

endmodule

// File: tb/tb_sat_accelerator_top.sv
// Self-checking bench for sat_accelerator_top (N = 4).
// Directed scenarios use hand-derived constants. The random scenario uses a
// truth-table reference model built from the command rules.
module tb_sat_accelerator_top;

  logic       clk;
  logic       resetN;
  logic [1:0] stateVal;
  logic [4:0] varPos;
  logic       negCtrl;
  logic       outSATRes;
`ifdef SAT_WITNESS_EN
  logic [3:0] satWitness;
`endif

  int tests;
  int fails;

  // Reference model state
  logic [15:0] m_clause;
  logic [15:0] m_cnf;
  logic        m_sat;
  logic [3:0]  m_wit;

  sat_accelerator_top #(.N(4)) dut (
    .clk       (clk),
    .resetN    (resetN),
    .stateVal  (stateVal),
    .varPos    (varPos),
    .negCtrl   (negCtrl),
    .outSATRes (outSATRes)
`ifdef SAT_WITNESS_EN
    ,
    .satWitness(satWitness)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model one command with the rules applied to each assignment in turn.
  task automatic model_step(input logic [1:0] op, input logic [4:0] v,
                            input logic n, input logic r);
    logic [15:0] nxt;
    if (r || op == 2'd0) begin
      m_clause = 16'd0;
      m_cnf    = 16'hFFFF;
      m_sat    = 1'b0;
      m_wit    = 4'd0;
    end else if (op == 2'd1) begin
      if (v < 5'd4) begin
        for (int a = 0; a < 16; a++) begin
          if ((((a >> v) & 1) == 1) != (n == 1'b1)) m_clause[a] = 1'b1;
        end
      end
    end else if (op == 2'd2) begin
      nxt   = m_cnf & m_clause;
      m_cnf = nxt;
      m_sat = (nxt != 16'd0);
      m_wit = 4'd0;
      for (int a = 15; a >= 0; a--) begin
        if (nxt[a]) m_wit = 4'(a);
      end
    end else begin
      m_clause = 16'd0;
    end
  endtask

  task automatic send(input logic [1:0] op, input logic [4:0] v,
                      input logic n, input logic r);
    resetN   = r;
    stateVal = op;
    varPos   = v;
    negCtrl  = n;
    @(posedge clk);
    model_step(op, v, n, r);
    @(negedge clk);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 5; i++) send(2'd0, 5'd0, 1'b0, 1'b1);
    tests++;
    if (outSATRes !== 1'b0) begin fails++; $display("FAIL reset_sat: got %b want 0", outSATRes); end
    tests++;
    if (dut.cnf_r !== 16'hFFFF) begin fails++; $display("FAIL reset_cnf: got %h want ffff", dut.cnf_r); end
    tests++;
    if (dut.clause_r !== 16'h0000) begin fails++; $display("FAIL reset_clause: got %h want 0000", dut.clause_r); end
    send(2'd0, 5'd0, 1'b0, 1'b0);
    tests++;
    if (outSATRes !== 1'b0 || dut.cnf_r !== 16'hFFFF || dut.clause_r !== 16'h0000) begin
      fails++;
      $display("FAIL op00_idle: got sat=%b cnf=%h clause=%h want 0/ffff/0000", outSATRes, dut.cnf_r, dut.clause_r);
    end
  endtask

  task automatic test_satisfiable();
    send(2'd0, 5'd0, 1'b0, 1'b0);
    send(2'd1, 5'd0, 1'b0, 1'b0);
    send(2'd1, 5'd1, 1'b0, 1'b0);
    send(2'd2, 5'd0, 1'b0, 1'b0);
    tests++;
    if (dut.cnf_r !== 16'hEEEE || outSATRes !== 1'b1) begin
      fails++;
      $display("FAIL sat_clause1: got cnf=%h sat=%b want eeee/1", dut.cnf_r, outSATRes);
    end
    send(2'd3, 5'd0, 1'b0, 1'b0);
    send(2'd1, 5'd0, 1'b1, 1'b0);
    send(2'd1, 5'd1, 1'b0, 1'b0);
    send(2'd2, 5'd0, 1'b0, 1'b0);
    tests++;
    if (dut.cnf_r !== 16'hCCCC || outSATRes !== 1'b1) begin
      fails++;
      $display("FAIL sat_clause2: got cnf=%h sat=%b want cccc/1", dut.cnf_r, outSATRes);
    end
`ifdef SAT_WITNESS_EN
    tests++;
    if (satWitness !== 4'd2) begin fails++; $display("FAIL sat_witness: got %0d want 2", satWitness); end
`endif
  endtask

  task automatic test_unsatisfiable();
    send(2'd0, 5'd0, 1'b0, 1'b0);
    send(2'd1, 5'd0, 1'b0, 1'b0);
    send(2'd2, 5'd0, 1'b0, 1'b0);
    send(2'd3, 5'd0, 1'b0, 1'b0);
    send(2'd1, 5'd0, 1'b1, 1'b0);
    send(2'd2, 5'd0, 1'b0, 1'b0);
    tests++;
    if (dut.cnf_r !== 16'h0000 || outSATRes !== 1'b0) begin
      fails++;
      $display("FAIL unsat: got cnf=%h sat=%b want 0000/0", dut.cnf_r, outSATRes);
    end
    send(2'd3, 5'd0, 1'b0, 1'b0);
    send(2'd1, 5'd1, 1'b0, 1'b0);
    send(2'd1, 5'd2, 1'b1, 1'b0);
    send(2'd2, 5'd0, 1'b0, 1'b0);
    tests++;
    if (outSATRes !== 1'b0) begin fails++; $display("FAIL unsat_sticky: got %b want 0", outSATRes); end
  endtask

  task automatic test_out_of_range();
    send(2'd0, 5'd0, 1'b0, 1'b0);
    send(2'd1, 5'd7, 1'b0, 1'b0);
    tests++;
    if (dut.clause_r !== 16'h0000) begin fails++; $display("FAIL oor_clause: got %h want 0000", dut.clause_r); end
    send(2'd1, 5'd31, 1'b1, 1'b0);
    send(2'd2, 5'd0, 1'b0, 1'b0);
    tests++;
    if (outSATRes !== 1'b0 || dut.cnf_r !== 16'h0000) begin
      fails++;
      $display("FAIL oor_empty_commit: got sat=%b cnf=%h want 0/0000", outSATRes, dut.cnf_r);
    end
  endtask

  task automatic test_no_autoclear();
    send(2'd0, 5'd0, 1'b0, 1'b0);
    send(2'd1, 5'd0, 1'b0, 1'b0);
    send(2'd2, 5'd0, 1'b0, 1'b0);
    send(2'd2, 5'd0, 1'b0, 1'b0);
    tests++;
    if (dut.cnf_r !== 16'hAAAA || dut.clause_r !== 16'hAAAA || outSATRes !== 1'b1) begin
      fails++;
      $display("FAIL no_autoclear: got cnf=%h clause=%h sat=%b want aaaa/aaaa/1", dut.cnf_r, dut.clause_r, outSATRes);
    end
  endtask

  task automatic test_reset_mid();
    send(2'd0, 5'd0, 1'b0, 1'b0);
    send(2'd1, 5'd0, 1'b0, 1'b0);
    send(2'd2, 5'd0, 1'b0, 1'b0);
    send(2'd1, 5'd2, 1'b0, 1'b1);
    tests++;
    if (dut.cnf_r !== 16'hFFFF || dut.clause_r !== 16'h0000 || outSATRes !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid: got cnf=%h clause=%h sat=%b want ffff/0000/0", dut.cnf_r, dut.clause_r, outSATRes);
    end
    send(2'd1, 5'd1, 1'b0, 1'b0);
    send(2'd2, 5'd0, 1'b0, 1'b0);
    tests++;
    if (dut.cnf_r !== 16'hCCCC || outSATRes !== 1'b1) begin
      fails++;
      $display("FAIL reset_mid_x1: got cnf=%h sat=%b want cccc/1", dut.cnf_r, outSATRes);
    end
  endtask

  task automatic test_back_to_back_random();
    logic [1:0] op;
    int         sel;
    send(2'd0, 5'd0, 1'b0, 1'b0);
    for (int i = 0; i < 600; i++) begin
      sel = $urandom_range(0, 99);
      if (sel < 8)       op = 2'd0;
      else if (sel < 60) op = 2'd1;
      else if (sel < 80) op = 2'd2;
      else               op = 2'd3;
      send(op, 5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 99) < 3) ? 1'b1 : 1'b0);
      tests++;
      if (outSATRes !== m_sat || dut.cnf_r !== m_cnf || dut.clause_r !== m_clause) begin
        fails++;
        $display("FAIL random[%0d]: got sat=%b cnf=%h clause=%h want %b/%h/%h",
                 i, outSATRes, dut.cnf_r, dut.clause_r, m_sat, m_cnf, m_clause);
      end
`ifdef SAT_WITNESS_EN
      tests++;
      if (satWitness !== m_wit) begin
        fails++;
        $display("FAIL random_witness[%0d]: got %0d want %0d", i, satWitness, m_wit);
      end
`endif
    end
  endtask

  initial begin
    tests    = 0;
    fails    = 0;
    resetN   = 1'b1;
    stateVal = 2'd0;
    varPos   = 5'd0;
    negCtrl  = 1'b0;
    m_clause = 16'd0;
    m_cnf    = 16'hFFFF;
    m_sat    = 1'b0;
    m_wit    = 4'd0;
    test_reset();
    test_satisfiable();
    test_unsatisfiable();
    test_out_of_range();
    test_no_autoclear();
    test_reset_mid();
    test_back_to_back_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
